axil_sig_reader: RTL

AXI-Lite read master that, once the CPU halts, fetches the RISCOF signature region word by word through a spare interconnect slave port and emits each word on a valid/ready output stream. It lets the signature be dumped by hardware, through the real bus path, rather than by peeking into RAM. It sits downstream of the CPU/interconnect/RAM subsystem and upstream of the bench's signature writer or a UART drain.

---
 rtl/z_core_pkg.sv | 16 +
 rtl/axil_sig_reader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/z_core_pkg.sv
// Shared core package: signature reader states and AXI-Lite constants.
// Imported by the bus-side helper blocks of the core test harness.
package z_core_pkg;

  typedef enum logic [2:0] {
    SR_IDLE,
    SR_AR,
    SR_R,
    SR_OUT,
    SR_DONE
  } sig_rd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_sig_reader.sv
// AXI-Lite read master that dumps the signature region word by word
// onto a valid/ready stream once the CPU has halted.
module axil_sig_reader
  import z_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] sig_begin,
  input  logic [ADDR_WIDTH-1:0] sig_end,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           word_count,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [ADDR_WIDTH-1:0] A_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(4);

  sig_rd_state_t r_state;
  sig_rd_state_t w_next;

  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [15:0]           r_cnt;

  logic [ADDR_WIDTH-1:0] w_beg;
  logic [ADDR_WIDTH-1:0] w_end;
  logic [ADDR_WIDTH-1:0] w_cur_nxt;
  logic                  w_last;
  logic                  w_unused;

  assign w_beg     = sig_begin & A_MASK;
  assign w_end     = sig_end & A_MASK;
  assign w_cur_nxt = r_cur + A_STEP;
  // A wrap to zero also ends the dump.
  assign w_last    = (w_cur_nxt == '0) || (w_cur_nxt >= r_end);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SR_IDLE: begin
        if (start) begin
          w_next = (w_end <= w_beg) ? SR_DONE : SR_AR;
        end
      end
      SR_AR: begin
        if (m_axil_arready) w_next = SR_R;
      end
      SR_R: begin
        if (m_axil_rvalid) w_next = SR_OUT;
      end
      SR_OUT: begin
        if (out_ready) begin
          w_next = w_last ? SR_DONE : SR_AR;
        end
      end
      SR_DONE: w_next = SR_IDLE;
      default: w_next = SR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= SR_IDLE;
      r_cur   <= '0;
      r_end   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == SR_IDLE && start) begin
        r_cur <= w_beg;
        r_end <= w_end;
        r_err <= 1'b0;
        r_cnt <= '0;
      end
      if (r_state == SR_R && m_axil_rvalid) begin
        r_data <= m_axil_rdata;
        if (m_axil_rresp != AXI_RESP_OKAY) r_err <= 1'b1;
      end
      if (r_state == SR_OUT && out_ready) begin
        r_cur <= w_cur_nxt;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Busy rises with the accepted start so an empty dump still shows it.
  assign busy = rstn & (
    (r_state == SR_IDLE && start) ||
    r_state == SR_AR ||
    r_state == SR_R ||
    r_state == SR_OUT);

  assign done       = (r_state == SR_DONE);
  assign err        = r_err;
  assign word_count = r_cnt;

  assign m_axil_araddr  = r_cur;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = (r_state == SR_AR);
  assign m_axil_rready  = (r_state == SR_R);

  assign m_axil_awaddr  = '0;
  assign m_axil_awprot  = '0;
  assign m_axil_awvalid = 1'b0;
  assign m_axil_wdata   = '0;
  assign m_axil_wstrb   = '0;
  assign m_axil_wvalid  = 1'b0;
  assign m_axil_bready  = 1'b1;

  assign out_data  = r_data;
  assign out_valid = (r_state == SR_OUT);

  assign w_unused = ^{m_axil_awready, m_axil_wready,
                      m_axil_bresp, m_axil_bvalid};

endmodule
